// File: rtl/mem_word_master_pkg.sv
// Shared types for the word-to-half-word memory master.
// State encoding and memory geometry constants.
package mem_access_pkg;

  localparam int MEM_WIDTH       = 16;
  localparam int HALVES_PER_WORD = 2;

  typedef enum logic [2:0] {
    IDLE,
    RD_HI,
    RD_LO,
    RD_CAP,
    WR_HI,
    WR_LO,
    RESP
  } state_e;

endpackage

// File: rtl/mem_word_master_if.sv
// CPU request/response handshake plus half-word memory port.
// master = word master view, slave = requester/memory view.
interface mem_word_master_if #(
  parameter int WORD_SIZE    = 32,
  parameter int ADDRESS_SIZE = 32,
  parameter int MEM_WIDTH    = 16
);

  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic [ADDRESS_SIZE-1:0] req_addr;
  logic [WORD_SIZE-1:0]    req_wdata;
  logic                    resp_valid;
  logic [WORD_SIZE-1:0]    resp_rdata;
  logic                    resp_err;
  logic [ADDRESS_SIZE-1:0] Address;
  logic [MEM_WIDTH-1:0]    WriteData;
  logic                    MemRead;
  logic                    MemWrite;
  logic [MEM_WIDTH-1:0]    ReadData;

  modport master (
    input  req_valid, req_write, req_addr,
    input  req_wdata, ReadData,
    output req_ready, resp_valid, resp_rdata,
    output resp_err, Address, WriteData,
    output MemRead, MemWrite
  );

  modport slave (
    output req_valid, req_write, req_addr,
    output req_wdata, ReadData,
    input  req_ready, resp_valid, resp_rdata,
    input  resp_err, Address, WriteData,
    input  MemRead, MemWrite
  );

endinterface

// File: rtl/mem_word_master.sv
// Splits 32-bit word requests into two big-endian half-word accesses.
// Option macro: MEM_WORD_MASTER_MISALIGN_TRAP_EN (trap req_addr[1:0]!=0).
module mem_word_master
  import mem_access_pkg::*;
#(
  parameter int WORD_SIZE    = 32,
  parameter int ADDRESS_SIZE = 32,
  parameter int MEM_WIDTH    = mem_access_pkg::MEM_WIDTH
) (
  input  logic clk,
  input  logic rst,
  mem_word_master_if.master bus
);

  localparam int A = ADDRESS_SIZE;
  localparam int W = WORD_SIZE;
  localparam int M = MEM_WIDTH;

  state_e         state_q, state_d;
  logic [A-1:0]   base_q, base_d;
  logic [W-1:0]   wdata_q, wdata_d;
  logic [M-1:0]   hi_q, hi_d;
  logic [W-1:0]   rdata_q, rdata_d;
  logic           err_q, err_d;
  logic           accept;
  logic           misalign;

`ifdef MEM_WORD_MASTER_MISALIGN_TRAP_EN
  assign misalign = |bus.req_addr[1:0];
`else
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^bus.req_addr[1:0];
  assign misalign = 1'b0;
`endif

  assign accept = bus.req_valid && (state_q == IDLE);

  // State and latched request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      wdata_q <= '0;
      hi_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      hi_q    <= hi_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next state, request latch and read word assembly.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    wdata_d = wdata_q;
    hi_d    = hi_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          base_d  = {1'b0, bus.req_addr[A-1:2], 1'b0};
          wdata_d = bus.req_wdata;
          err_d   = misalign;
          if (misalign)
            state_d = RESP;
          else if (bus.req_write)
            state_d = WR_HI;
          else
            state_d = RD_HI;
        end
      end
      RD_HI:  state_d = RD_LO;
      RD_LO: begin
        hi_d    = bus.ReadData;
        state_d = RD_CAP;
      end
      RD_CAP: begin
        rdata_d = {hi_q, bus.ReadData};
        state_d = RESP;
      end
      WR_HI:  state_d = WR_LO;
      WR_LO:  state_d = RESP;
      RESP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory strobes and response decode from state.
  always_comb begin
    bus.req_ready  = (state_q == IDLE);
    bus.resp_valid = (state_q == RESP);
    bus.resp_err   = (state_q == RESP) && err_q;
    bus.resp_rdata = rdata_q;
    bus.MemRead    = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.Address    = '0;
    bus.WriteData  = '0;
    unique case (state_q)
      RD_HI: begin
        bus.MemRead = 1'b1;
        bus.Address = base_q;
      end
      RD_LO: begin
        bus.MemRead = 1'b1;
        bus.Address = base_q + A'(1);
      end
      WR_HI: begin
        bus.MemWrite  = 1'b1;
        bus.Address   = base_q;
        bus.WriteData = wdata_q[W-1:M];
      end
      WR_LO: begin
        bus.MemWrite  = 1'b1;
        bus.Address   = base_q + A'(1);
        bus.WriteData = wdata_q[M-1:0];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_word_master.sv
// Directed bench for mem_word_master with a registered half-word memory.
// Expectations follow MEM_WORD_MASTER_MISALIGN_TRAP_EN when defined.
module tb_mem_word_master;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
    logic        err;
    int          nstb;
    logic [31:0] a0;
    logic [15:0] d0;
    logic [15:0] d1;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_word_master_if #(
    .WORD_SIZE(32), .ADDRESS_SIZE(32), .MEM_WIDTH(16)
  ) bus ();

  mem_word_master #(
    .WORD_SIZE(32), .ADDRESS_SIZE(32), .MEM_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [15:0] mem [0:1023];
  logic [15:0] rd_q;
  logic        pl_en;
  logic [9:0]  pl_addr;
  logic [15:0] pl_data;
  logic        both_seen = 1'b0;

  assign bus.ReadData = rd_q;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bus.MemWrite) mem[bus.Address[9:0]] <= bus.WriteData;
    if (bus.MemRead) rd_q <= mem[bus.Address[9:0]];
  end

  always @(negedge clk)
    if (bus.MemRead && bus.MemWrite) both_seen <= 1'b1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_req(input vec_t v, input int idx);
    logic [31:0] a [2];
    logic [15:0] d [2];
    int          n;
    int          lat;
    int          k;
    int          kind_bad;
    logic [31:0] rdata;
    logic        err;
    n = 0; lat = -1; kind_bad = 0; k = 0;
    rdata = '0; err = 1'b0;
    a[0] = '0; a[1] = '0; d[0] = '0; d[1] = '0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = v.wr;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    while (!bus.req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("v%0d ready", idx), 32'(bus.req_ready), 32'd1);
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      @(negedge clk);
      if (c == 1) bus.req_valid = 1'b0;
      if (bus.MemRead || bus.MemWrite) begin
        if (n < 2) begin
          a[n] = bus.Address;
          d[n] = bus.WriteData;
        end
        if (bus.MemWrite != v.wr) kind_bad++;
        n++;
      end
      if (bus.resp_valid) begin
        lat   = c;
        rdata = bus.resp_rdata;
        err   = bus.resp_err;
      end
    end
    chk($sformatf("v%0d latency", idx), 32'(lat), 32'(v.lat));
    chk($sformatf("v%0d err", idx), 32'(err), 32'(v.err));
    chk($sformatf("v%0d rdata", idx), rdata, v.rdata);
    chk($sformatf("v%0d strobes", idx), 32'(n), 32'(v.nstb));
    chk($sformatf("v%0d kind", idx), 32'(kind_bad), 32'd0);
    if (v.nstb > 0)
      chk($sformatf("v%0d addr0", idx), a[0], v.a0);
    if (v.nstb > 1)
      chk($sformatf("v%0d addr1", idx), a[1], v.a0 + 32'd1);
    if (v.wr && v.nstb > 1) begin
      chk($sformatf("v%0d wd0", idx), 32'(d[0]), 32'(v.d0));
      chk($sformatf("v%0d wd1", idx), 32'(d[1]), 32'(v.d1));
    end
  endtask

  vec_t tbl [8];

  initial begin
    int lows;
    int rv_c;
    int acc2;
    int lat2;
    int rv_cnt;
    logic [31:0] rd2;

    tbl[0] = '{1'b0, 32'h200, 32'h0, 4, 32'hDEADBEEF, 1'b0, 2,
               32'h100, 16'h0, 16'h0};
    tbl[1] = '{1'b1, 32'h40, 32'h12345678, 3, 32'hDEADBEEF, 1'b0, 2,
               32'h20, 16'h1234, 16'h5678};
    tbl[2] = '{1'b0, 32'h40, 32'h0, 4, 32'h12345678, 1'b0, 2,
               32'h20, 16'h0, 16'h0};
`ifdef MEM_WORD_MASTER_MISALIGN_TRAP_EN
    tbl[3] = '{1'b0, 32'h202, 32'h0, 1, 32'h12345678, 1'b1, 0,
               32'h0, 16'h0, 16'h0};
    tbl[4] = '{1'b1, 32'h203, 32'hCAFEF00D, 1, 32'h12345678, 1'b1, 0,
               32'h0, 16'h0, 16'h0};
    tbl[5] = '{1'b0, 32'h200, 32'h0, 4, 32'hDEADBEEF, 1'b0, 2,
               32'h100, 16'h0, 16'h0};
`else
    tbl[3] = '{1'b0, 32'h202, 32'h0, 4, 32'hDEADBEEF, 1'b0, 2,
               32'h100, 16'h0, 16'h0};
    tbl[4] = '{1'b1, 32'h203, 32'hCAFEF00D, 3, 32'hDEADBEEF, 1'b0, 2,
               32'h100, 16'hCAFE, 16'hF00D};
    tbl[5] = '{1'b0, 32'h200, 32'h0, 4, 32'hCAFEF00D, 1'b0, 2,
               32'h100, 16'h0, 16'h0};
`endif
    tbl[6] = '{1'b1, 32'hFFFFFFFC, 32'h0000FFFF, 3, tbl[5].rdata, 1'b0, 2,
               32'h7FFFFFFE, 16'h0000, 16'hFFFF};
    tbl[7] = '{1'b0, 32'hFFFFFFFC, 32'h0, 4, 32'h0000FFFF, 1'b0, 2,
               32'h7FFFFFFE, 16'h0, 16'h0};

    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;

    @(negedge clk);
    pl_en = 1'b1; pl_addr = 10'h100; pl_data = 16'hDEAD;
    @(negedge clk);
    pl_addr = 10'h101; pl_data = 16'hBEEF;
    @(negedge clk);
    pl_en = 1'b0;

    chk("rst ready", 32'(bus.req_ready), 32'd1);
    chk("rst resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst rdata", bus.resp_rdata, 32'h0);
    chk("rst err", 32'(bus.resp_err), 32'd0);
    chk("rst MemRead", 32'(bus.MemRead), 32'd0);
    chk("rst MemWrite", 32'(bus.MemWrite), 32'd0);
    chk("rst Address", bus.Address, 32'h0);
    chk("rst WriteData", 32'(bus.WriteData), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_req(tbl[i], i);

    // back-to-back: write then read of 0x80 with req_valid held
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 32'h80;
    bus.req_wdata = 32'hA5A55A5A;
    chk("b2b ready0", 32'(bus.req_ready), 32'd1);
    lows = 0; rv_c = -1; acc2 = -1;
    for (int c = 1; c <= 12 && acc2 < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.req_write = 1'b0;
        bus.req_wdata = '0;
      end
      if (bus.resp_valid && rv_c < 0) rv_c = c;
      if (bus.req_ready) acc2 = c;
      else lows++;
    end
    chk("b2b ready lows", 32'(lows), 32'd3);
    chk("b2b wr resp", 32'(rv_c), 32'd3);
    chk("b2b accept2", 32'(acc2), 32'd4);
    lat2 = -1; rd2 = '0;
    for (int c = 1; c <= 12 && lat2 < 0; c++) begin
      @(negedge clk);
      if (c == 1) bus.req_valid = 1'b0;
      if (bus.resp_valid) begin
        lat2 = c;
        rd2  = bus.resp_rdata;
      end
    end
    chk("b2b rd latency", 32'(lat2), 32'd4);
    chk("b2b rd data", rd2, 32'hA5A55A5A);

    // reset asserted while in WR_LO
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 32'h60;
    bus.req_wdata = 32'h11112222;
    chk("rmw ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("rmw wr_hi", 32'(bus.MemWrite), 32'd1);
    @(negedge clk);
    chk("rmw wr_lo", 32'(bus.MemWrite), 32'd1);
    chk("rmw wr_lo addr", bus.Address, 32'h31);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rmw MemWrite", 32'(bus.MemWrite), 32'd0);
    chk("rmw MemRead", 32'(bus.MemRead), 32'd0);
    chk("rmw ready", 32'(bus.req_ready), 32'd1);
    rv_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      if (bus.resp_valid) rv_cnt++;
      @(negedge clk);
    end
    chk("rmw no resp", 32'(rv_cnt), 32'd0);

    chk("never both strobes", 32'(both_seen), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_word_master.md
Name: mem_word_master

Overview:
- Initiator side of the unified instruction/data memory interface.
- Accepts 32-bit word read/write requests from the multi-cycle datapath/controller.
- Sequences each request as two 16-bit half-word accesses on the MemRead/MemWrite/Address/WriteData/ReadData memory port.
- Returns the assembled word, or a write acknowledge, with a one-cycle response pulse.

Parameters:
- WORD_SIZE, 32, CPU-side data width; must equal 2*MEM_WIDTH.
- ADDRESS_SIZE, 32, width of the CPU byte address and of the memory half-word index.
- MEM_WIDTH, 16, memory-side data width (one half-word per memory location).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid and req_ready are both high.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDRESS_SIZE  byte address.
- req_wdata  in  WORD_SIZE  write data.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  WORD_SIZE  read word; held until the next read completes.
- resp_err  out  1  misalignment flag, qualified by resp_valid.
- Address  out  ADDRESS_SIZE  memory half-word index.
- WriteData  out  MEM_WIDTH  memory write data.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- ReadData  in  MEM_WIDTH  memory read data, registered by the memory and valid one cycle after MemRead.

Behaviour:
- Reset: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, MemRead=0, MemWrite=0, Address=0, WriteData=0.
- On acceptance, latch:
  - write flag;
  - base = {1'b0, req_addr[ADDRESS_SIZE-1:2], 1'b0}, i.e. byte address >>1 with bit 0 cleared;
  - req_wdata.
- Big-endian layout: upper half-word at base, lower half-word at base+1.
- base+1 cannot overflow.
- Memory-side outputs decode combinationally from the state register and the latched request.
- MemRead and MemWrite are never high together.
- Both strobes are 0 in IDLE and RESP.
- State machine (one transition per clk):
  - IDLE: accept → RD_HI or WR_HI.
  - RD_HI: MemRead=1, Address=base → RD_LO.
  - RD_LO: MemRead=1, Address=base+1; capture ReadData into upper half → RD_CAP.
  - RD_CAP: capture ReadData into lower half → RESP.
  - WR_HI: MemWrite=1, Address=base, WriteData=wdata[31:16] → WR_LO.
  - WR_LO: MemWrite=1, Address=base+1, WriteData=wdata[15:0] → RESP.
  - RESP: resp_valid=1 → IDLE.
- Latency, counting the acceptance cycle as cycle 0: read resp_valid in cycle 4; write resp_valid in cycle 3.
- Back-to-back: the next request is accepted in the cycle after RESP.
- There is no response backpressure.
- req_valid outside IDLE is ignored; the requester holds its request.
- Reset mid-operation: the state returns to IDLE at the reset edge and the strobes drop.
  - An interrupted write may leave only the upper half-word updated. This is accepted and is not rolled back.
  - No resp_valid is issued for the aborted request.
- resp_err is 0 for every response unless MISALIGN_TRAP_EN is defined.

Optional Feature:
- Macro: MEM_WORD_MASTER_MISALIGN_TRAP_EN.
- Defined: an accepted request with req_addr[1:0] != 0 goes IDLE → RESP directly.
  - No MemRead or MemWrite is issued.
  - resp_valid=1 and resp_err=1.
  - resp_rdata keeps its previous value.
- Undefined: req_addr[1:0] is ignored, the access proceeds to the aligned word, and resp_err is tied 0.

Decomposition:
- Shared package mem_access_pkg holds:
  - the state enum: IDLE, RD_HI, RD_LO, RD_CAP, WR_HI, WR_LO, RESP;
  - MEM_WIDTH;
  - HALVES_PER_WORD = 2.
- No sub-module; the sequencer and word assembler form one block.

Test Plan:
- Read assembly:
  - Stimulus: preload mem[0x100]=16'hDEAD, mem[0x101]=16'hBEEF; read req_addr=0x200.
  - Required: MemRead with Address 0x100 then 0x101; resp_valid in cycle 4 with resp_rdata=32'hDEADBEEF; resp_err=0.
- Write split:
  - Stimulus: write req_addr=0x40, req_wdata=32'h12345678.
  - Required: MemWrite with Address 0x20/WriteData 16'h1234, then 0x21/16'h5678; resp_valid in cycle 3; a read-back of 0x40 returns 32'h12345678.
- Back-to-back:
  - Stimulus: hold req_valid with a write to 0x80 followed by a read of 0x80.
  - Required: req_ready low for 3 cycles then high; the second request is accepted the cycle after RESP; no cycle has MemRead=MemWrite=1.
- Reset mid-write:
  - Stimulus: assert rst in WR_LO.
  - Required: next cycle state=IDLE, strobes=0, req_ready=1, no resp_valid.
- Misaligned access, req_addr=0x202:
  - With the macro: resp_valid one cycle after acceptance, resp_err=1, zero memory strobes.
  - Without the macro: behaves exactly as req_addr=0x200.
